fixed_point_unit_seq: RTL and testbench
=======================================

FIXED_POINT_UNIT_SEQ -- requirements
Module: fixed_point_unit_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits; legal values are multiples of 16, at least 16.
REQ-002 SHALL have parameter FBITS, default 10, meaning fractional bits of the signed two's-complement Q format; WIDTH+FBITS SHALL be even.
REQ-003 SHALL have parameter SATURATE, default 1, meaning 1 = clamp on overflow and 0 = wrap on overflow.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  request; accepted on an edge where start=1 and busy=0.
REQ-007 SHALL have port operation  input  3  opcode: 000 ADD, 001 SUB, 010 MUL, 011 SQRT, others illegal.
REQ-008 SHALL have ports operand_1 and operand_2  input  WIDTH  signed fixed-point operands; operand_2 is unused by SQRT.
REQ-009 SHALL have port result  output  WIDTH  registered result; holds its value until the next completion.
REQ-010 SHALL have port ready  output  1  one-cycle completion pulse.
REQ-011 SHALL have port busy  output  1  operation in flight.
REQ-012 SHALL have ports overflow and invalid  output  1 each  status flags; both are updated with ready and held until the next completion.

Function
REQ-013 SHALL latch operation and operands on the accept edge; later input changes SHALL have no effect on the operation in flight.
REQ-014 SHALL use FSM states IDLE, MUL_ACC, SQRT_ITER and FINISH; SHALL have no other reachable states, and any unreachable encoding SHALL return to IDLE.
REQ-015 ADD/SUB SHALL compute in the accept edge and raise ready on the next cycle (latency L=1); busy SHALL stay 0.
REQ-016 ADD/SUB overflow SHALL be flagged when the true sum or difference lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
REQ-017 For ADD/SUB with SATURATE=1, result SHALL clamp to 0x7FF..F or 0x800..0; with SATURATE=0, result SHALL wrap, and overflow SHALL still be flagged.
REQ-018 MUL SHALL reuse one 16x16 unsigned multiplier over operand magnitudes, one partial product per cycle.
REQ-019 MUL SHALL take N=(WIDTH/16)^2 partials on edges 1..N after accept, each shifted by 16*(i+j), accumulated into a 2*WIDTH register.
REQ-020 MUL SHALL finalise on edge N+1: Q = accumulator >> FBITS (truncate toward zero), apply sign = sign1 XOR sign2, check range, and raise ready; latency L=N+1 (5 for WIDTH=32).
REQ-021 MUL overflow SHALL be flagged when Q > 2^(WIDTH-1)-1 for a positive result or Q > 2^(WIDTH-1) for a negative result; saturation SHALL follow REQ-017.
REQ-022 SQRT SHALL compute floor(sqrt(operand_1 * 2^FBITS)) with a restoring digit-by-digit algorithm (2 bits in, 1 root bit out per cycle) for ITER=(WIDTH+FBITS)/2 cycles.
REQ-023 SQRT latency SHALL be L=ITER+1 (22 for 32/10).
REQ-024 SQRT of a negative operand SHALL give result=0 and invalid=1 at L=1.
REQ-025 An illegal opcode SHALL give result=0 and invalid=1 at L=1.
REQ-026 busy SHALL be 1 from the accept edge until the edge that raises ready, and 0 in the ready cycle.
REQ-027 A new start in the ready cycle SHALL be accepted, giving back-to-back operation.
REQ-028 start while busy=1 SHALL be ignored, with no queueing.
REQ-029 The flags not applicable to an operation SHALL be written 0 at that operation's completion.

Reset
REQ-030 With reset=1 at an edge: state=IDLE, result=0, ready=0, busy=0, overflow=0, invalid=0, and datapath registers cleared.
REQ-031 Reset SHALL take priority over start; an operation in flight SHALL be aborted with no ready pulse.
REQ-032 The first start after reset deasserts SHALL be accepted normally.

Verification (WIDTH=32, FBITS=10, SATURATE=1)
REQ-033 ADD 0x600 (1.5) + 0x800 (2.0) -> next cycle ready=1, result=0xE00, overflow=0; with a SUB start in that ready cycle, 0x600-0x800 -> ready next cycle, result=0xFFFFFE00.
REQ-034 MUL 0x600*0x800 -> ready exactly 5 cycles after accept, result=0xC00; MUL 0xFFFFFA00*0x800 -> result=0xFFFFF400; busy=1 during cycles 1-4.
REQ-035 MUL 0x7FFFFFFF*0x800 -> overflow=1, result=0x7FFFFFFF; ADD 0x7FFFFFFF+0x400 -> overflow=1, result=0x7FFFFFFF; with SATURATE=0 -> result=0x800003FF.
REQ-036 SQRT 0x1000 (4.0) -> ready 22 cycles after accept, result=0x800; SQRT 0x800 -> result=0x5A8; SQRT 0xFFFFF000 -> ready at 1 cycle, result=0, invalid=1.
REQ-037 SQRT started, reset pulsed at cycle 10 -> no ready, busy=0, result=0 next cycle; an ADD issued 2 cycles later completes normally; start pulses during busy are ignored.

Source files
------------

// File: rtl/fixed_point_unit_seq.sv
// Sequential signed Q-format ALU: ADD/SUB in 1 cycle, MUL via a shared 16x16 multiplier, SQRT digit-by-digit.
// One operation in flight; start is ignored while busy, and ready pulses for one cycle with result and flags.
module fixed_point_unit_seq #(
   parameter int WIDTH    = 32,
   parameter int FBITS    = 10,
   parameter bit SATURATE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       operation,
   input  logic [WIDTH-1:0] operand_1,
   input  logic [WIDTH-1:0] operand_2,
   output logic [WIDTH-1:0] result,
   output logic             ready,
   output logic             busy,
   output logic             overflow,
   output logic             invalid
);

   localparam int NC   = WIDTH / 16;
   localparam int ITER = (WIDTH + FBITS) / 2;
   localparam int RW   = WIDTH + FBITS;
   localparam int ACCW = 2 * WIDTH;
   localparam int CW   = $clog2(ITER + 1);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_MUL  = 3'b010;
   localparam logic [2:0] OP_SQRT = 3'b011;

   localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, MUL_ACC, SQRT_ITER, FINISH} state_t;

   state_t state, state_nxt;
   logic   accept, mul_last, sqrt_last, op_is_mul;

   logic             mul_sign;
   logic [WIDTH-1:0] a_mag, b_mag, op1_mag, op2_mag;
   logic [ACCW-1:0]  acc, pp_shift, mul_q;
   logic [CW-1:0]    mul_i, mul_j, cnt;
   logic [15:0]      a_slice, b_slice;
   logic [31:0]      pp;
   logic             mul_ov;
   logic [WIDTH-1:0] mul_res;

   logic [RW-1:0]    rad;
   logic [ITER:0]    rem;
   logic [ITER-1:0]  root;
   logic [ITER+2:0]  sq_rem_t, sq_trial, sq_diff;
   logic             sq_ge;

   logic [WIDTH:0]   as_sum;
   logic             as_ov;
   logic [WIDTH-1:0] as_res;

   // Single-cycle operations complete through this stage so result and ready appear together.
   logic             pend_vld, pend_ov, pend_inv;
   logic [WIDTH-1:0] pend_res;

   assign accept    = start && !busy;
   assign mul_last  = (mul_i == CW'(NC - 1)) && (mul_j == CW'(NC - 1));
   assign sqrt_last = (cnt == CW'(ITER - 1));
   assign op1_mag   = operand_1[WIDTH-1] ? -operand_1 : operand_1;
   assign op2_mag   = operand_2[WIDTH-1] ? -operand_2 : operand_2;

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && operation == OP_MUL)
               state_nxt = MUL_ACC;
            else if (accept && operation == OP_SQRT && !operand_1[WIDTH-1])
               state_nxt = SQRT_ITER;
         end
         MUL_ACC:   if (mul_last)  state_nxt = FINISH;
         SQRT_ITER: if (sqrt_last) state_nxt = FINISH;
         FINISH:    state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
   end

   always_comb begin
      as_sum = (operation == OP_SUB) ? {operand_1[WIDTH-1], operand_1} - {operand_2[WIDTH-1], operand_2}
                                     : {operand_1[WIDTH-1], operand_1} + {operand_2[WIDTH-1], operand_2};
      as_ov  = as_sum[WIDTH] ^ as_sum[WIDTH-1];
      as_res = as_sum[WIDTH-1:0];
      if (as_ov && SATURATE) as_res = as_sum[WIDTH] ? MIN_NEG : MAX_POS;
   end

   always_comb begin
      a_slice  = a_mag[mul_i*16 +: 16];
      b_slice  = b_mag[mul_j*16 +: 16];
      pp       = 32'(a_slice) * 32'(b_slice);
      pp_shift = ACCW'(pp) << (16 * (mul_i + mul_j));
      mul_q    = acc >> FBITS;
      // Negative results may reach one step further than positive ones.
      mul_ov   = mul_sign ? (mul_q > ACCW'(MIN_NEG)) : (mul_q > ACCW'(MAX_POS));
      mul_res  = mul_sign ? -mul_q[WIDTH-1:0] : mul_q[WIDTH-1:0];
      if (mul_ov && SATURATE) mul_res = mul_sign ? MIN_NEG : MAX_POS;
   end

   always_comb begin
      sq_rem_t = {rem, rad[RW-1 -: 2]};
      sq_trial = {1'b0, root, 2'b01};
      sq_ge    = (sq_rem_t >= sq_trial);
      sq_diff  = sq_rem_t - sq_trial;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         result    <= '0;
         ready     <= 1'b0;
         overflow  <= 1'b0;
         invalid   <= 1'b0;
         pend_vld  <= 1'b0;
         pend_res  <= '0;
         pend_ov   <= 1'b0;
         pend_inv  <= 1'b0;
         op_is_mul <= 1'b0;
         mul_sign  <= 1'b0;
         a_mag     <= '0;
         b_mag     <= '0;
         acc       <= '0;
         mul_i     <= '0;
         mul_j     <= '0;
         rad       <= '0;
         rem       <= '0;
         root      <= '0;
         cnt       <= '0;
      end else begin
         ready    <= 1'b0;
         pend_vld <= 1'b0;
         if (pend_vld) begin
            result   <= pend_res;
            overflow <= pend_ov;
            invalid  <= pend_inv;
            ready    <= 1'b1;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  pend_ov   <= 1'b0;
                  pend_inv  <= 1'b0;
                  pend_res  <= '0;
                  op_is_mul <= (operation == OP_MUL);
                  case (operation)
                     OP_ADD, OP_SUB: begin
                        pend_vld <= 1'b1;
                        pend_res <= as_res;
                        pend_ov  <= as_ov;
                     end
                     OP_MUL: begin
                        mul_sign <= operand_1[WIDTH-1] ^ operand_2[WIDTH-1];
                        a_mag    <= op1_mag;
                        b_mag    <= op2_mag;
                        acc      <= '0;
                        mul_i    <= '0;
                        mul_j    <= '0;
                     end
                     OP_SQRT: begin
                        if (operand_1[WIDTH-1]) begin
                           pend_vld <= 1'b1;
                           pend_inv <= 1'b1;
                        end else begin
                           rad  <= RW'(operand_1) << FBITS;
                           rem  <= '0;
                           root <= '0;
                           cnt  <= '0;
                        end
                     end
                     default: begin
                        pend_vld <= 1'b1;
                        pend_inv <= 1'b1;
                     end
                  endcase
               end
            end
            MUL_ACC: begin
               acc <= acc + pp_shift;
               if (mul_j == CW'(NC - 1)) begin
                  mul_j <= '0;
                  mul_i <= mul_i + 1'b1;
               end else begin
                  mul_j <= mul_j + 1'b1;
               end
            end
            SQRT_ITER: begin
               rad  <= rad << 2;
               rem  <= sq_ge ? (ITER+1)'(sq_diff) : (ITER+1)'(sq_rem_t);
               root <= {root[ITER-2:0], sq_ge};
               cnt  <= cnt + 1'b1;
            end
            FINISH: begin
               ready    <= 1'b1;
               invalid  <= 1'b0;
               overflow <= op_is_mul ? mul_ov : 1'b0;
               result   <= op_is_mul ? mul_res : WIDTH'(root);
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fixed_point_unit_seq.sv
// Randomized and directed bench for fixed_point_unit_seq (32/10), saturating and wrapping instances side by side.
module tb_fixed_point_unit_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [2:0]  operation;
   logic [31:0] operand_1, operand_2;
   logic [31:0] result, result_w;
   logic        ready, busy, overflow, invalid;
   logic        ready_w, busy_w, overflow_w, invalid_w;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .SATURATE(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .operand_1(operand_1), .operand_2(operand_2), .result(result),
      .ready(ready), .busy(busy), .overflow(overflow), .invalid(invalid)
   );

   fixed_point_unit_seq #(.WIDTH(32), .FBITS(10), .SATURATE(1'b0)) dut_wrap (
      .clk(clk), .reset(reset), .start(start), .operation(operation),
      .operand_1(operand_1), .operand_2(operand_2), .result(result_w),
      .ready(ready_w), .busy(busy_w), .overflow(overflow_w), .invalid(invalid_w)
   );

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Plain-arithmetic reference: exact results in 64-bit, then range-checked.
   function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r_sat, output logic [31:0] r_wrap,
                                 output logic ov, output logic inv, output int lat);
      longint maxp = 64'sd2147483647;
      longint minn = -64'sd2147483648;
      longint sa, sb, s, p, mag, q, v, x, rt, t;
      logic neg;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      r_sat = '0; r_wrap = '0; ov = 1'b0; inv = 1'b0; lat = 1;
      case (op)
         3'd0, 3'd1: begin
            s      = (op == 3'd0) ? sa + sb : sa - sb;
            ov     = (s > maxp) || (s < minn);
            r_wrap = s[31:0];
            r_sat  = ov ? ((s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF) : r_wrap;
         end
         3'd2: begin
            lat    = 5;
            p      = sa * sb;
            neg    = a[31] ^ b[31];
            mag    = (p < 0) ? -p : p;
            q      = mag / 1024;
            ov     = neg ? (q > 64'sd2147483648) : (q > maxp);
            v      = neg ? -q : q;
            r_wrap = v[31:0];
            r_sat  = ov ? (neg ? 32'h8000_0000 : 32'h7FFF_FFFF) : r_wrap;
         end
         3'd3: begin
            if (sa < 0) begin
               inv = 1'b1;
            end else begin
               lat = 22;
               x   = sa * 1024;
               rt  = 0;
               for (int k = 20; k >= 0; k--) begin
                  t = rt + (64'sd1 <<< k);
                  if (t * t <= x) rt = t;
               end
               r_wrap = rt[31:0];
               r_sat  = r_wrap;
            end
         end
         default: inv = 1'b1;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge where ready is seen (or the bound expires).
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
      logic [31:0] e_sat, e_wrap;
      logic        e_ov, e_inv;
      int          e_lat, lat;
      bit          busy_ok;
      model(op, a, b, e_sat, e_wrap, e_ov, e_inv, e_lat);
      start = 1'b1; operation = op; operand_1 = a; operand_2 = b;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; operation = 3'($urandom); operand_1 = $urandom; operand_2 = $urandom;
      lat = 0; busy_ok = 1'b1;
      while (!ready && lat < 40) begin
         if (busy !== (e_lat > 1)) busy_ok = 1'b0;
         start = (e_lat > 1) ? 1'($urandom_range(0, 1)) : 1'b0;
         @(posedge clk); lat++;
         @(negedge clk);
      end
      start = 1'b0;
      check_val({tag, ".latency"},  64'(lat), 64'(e_lat));
      check_val({tag, ".result"},   result,   e_sat);
      check_val({tag, ".result_w"}, result_w, e_wrap);
      check_val({tag, ".overflow"}, {overflow, overflow_w}, {e_ov, e_ov});
      check_val({tag, ".invalid"},  invalid,  e_inv);
      check_val({tag, ".ready_w"},  ready_w,  1'b1);
      check_val({tag, ".busy_run"}, busy_ok,  1'b1);
      check_val({tag, ".busy_end"}, busy,     1'b0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 32'h000F_FFFF));
         2:       return -32'($urandom_range(0, 32'h000F_FFFF));
         default: return {$urandom_range(0, 1) ? 16'h7FFF : 16'h8000, 16'($urandom)};
      endcase
   endfunction

   initial begin
      bit saw_ready;
      reset = 1'b1; start = 1'b0; operation = '0; operand_1 = '0; operand_2 = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_val("rst.result",   result,   32'h0);
      check_val("rst.ready",    ready,    1'b0);
      check_val("rst.busy",     busy,     1'b0);
      check_val("rst.flags",    {overflow, invalid}, 2'b00);
      reset = 1'b0;

      do_op(3'd0, 32'h0000_0600, 32'h0000_0800, "add");
      do_op(3'd1, 32'h0000_0600, 32'h0000_0800, "sub_b2b");
      do_op(3'd2, 32'h0000_0600, 32'h0000_0800, "mul");
      do_op(3'd2, 32'hFFFF_FA00, 32'h0000_0800, "mul_neg");
      do_op(3'd2, 32'h7FFF_FFFF, 32'h0000_0800, "mul_ovf");
      do_op(3'd2, 32'h8000_0000, 32'h0000_0400, "mul_minneg");
      do_op(3'd2, 32'h8000_0000, 32'hFFFF_FC00, "mul_minneg_ovf");
      do_op(3'd0, 32'h7FFF_FFFF, 32'h0000_0400, "add_ovf");
      do_op(3'd1, 32'h8000_0000, 32'h0000_0001, "sub_ovf");
      do_op(3'd3, 32'h0000_1000, 32'h0, "sqrt4");
      do_op(3'd3, 32'h0000_0800, 32'h0, "sqrt2");
      do_op(3'd3, 32'hFFFF_F000, 32'h0, "sqrt_neg");
      do_op(3'd3, 32'h7FFF_FFFF, 32'h0, "sqrt_max");
      do_op(3'd6, 32'h1234_5678, 32'h0, "illegal");

      // Abort a square root mid-flight with reset.
      start = 1'b1; operation = 3'd3; operand_1 = 32'h0000_1000; operand_2 = '0;
      @(posedge clk);
      @(negedge clk);
      saw_ready = 1'b0;
      for (int i = 1; i < 10; i++) begin
         start = 1'($urandom_range(0, 1));
         @(posedge clk);
         @(negedge clk);
         if (ready) saw_ready = 1'b1;
      end
      reset = 1'b1; start = 1'b1; operation = 3'd0;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0; start = 1'b0;
      check_val("abort.ready",     ready,     1'b0);
      check_val("abort.busy",      busy,      1'b0);
      check_val("abort.result",    result,    32'h0);
      check_val("abort.no_ready",  saw_ready, 1'b0);
      repeat (2) @(negedge clk);
      do_op(3'd0, 32'h0000_0C00, 32'hFFFF_FC00, "after_abort");

      for (int n = 0; n < 80; n++) begin
         logic [2:0] op;
         op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) @(negedge clk);
         do_op(op, pick_operand(), pick_operand(), $sformatf("rand%0d", n));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
